// File: rtl/renkon_act.sv
// renkon_act: per-lane activation unit with a two-stage valid/ready pipeline.
// Each beat carries the config captured at acceptance; config writes never touch in-flight beats.
module renkon_act #(
    parameter int DWIDTH = 16,
    parameter int LANE   = 8,
    parameter int CWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [1:0]               cfg_mode,
    input  logic [3:0]               cfg_shift,
    input  logic [DWIDTH-1:0]        cfg_clip,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [LANE*DWIDTH-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [LANE*DWIDTH-1:0]   out_data,
    output logic [CWIDTH-1:0]        out_count
);

    localparam int W = LANE * DWIDTH;
    localparam logic [DWIDTH-1:0] CLIP_MAX = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic [DWIDTH-1:0] ZERO = '0;

    logic [1:0]        mode_q;
    logic [3:0]        shift_q;
    logic [DWIDTH-1:0] clip_q;

    logic              s1_valid;
    logic              s1_last;
    logic [W-1:0]      s1_data;
    logic [1:0]        s1_mode;
    logic [3:0]        s1_shift;
    logic [DWIDTH-1:0] s1_clip;

    logic [W-1:0]      act_data;
    logic              advance;

    function automatic logic [DWIDTH-1:0] act_lane(
        input logic [DWIDTH-1:0] x,
        input logic [1:0]        mode,
        input logic [3:0]        shift,
        input logic [DWIDTH-1:0] clip
    );
        logic              x_neg;
        logic              x_pos;
        logic              c_pos;
        logic [DWIDTH-1:0] y;
        x_neg = x[DWIDTH-1];
        x_pos = !x_neg && (x != ZERO);
        c_pos = !clip[DWIDTH-1] && (clip != ZERO);
        y = x;
        case (mode)
            2'd0: y = x;
            2'd1: y = x_pos ? x : ZERO;
            2'd2: y = x_neg ? $unsigned($signed(x) >>> shift) : x;
            default: begin
                if (!c_pos || !x_pos)
                    y = ZERO;
                else if ($signed(x) > $signed(clip))
                    y = clip;
                else
                    y = x;
            end
        endcase
        return y;
    endfunction

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Config registers; a write affects beats accepted after this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= 2'd1;
            shift_q <= 4'd0;
            clip_q  <= CLIP_MAX;
        end else if (cfg_we) begin
            mode_q  <= cfg_mode;
            shift_q <= cfg_shift;
            clip_q  <= cfg_clip;
        end
    end

    // Stage 1: capture the accepted beat together with its config snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= 2'd1;
            s1_shift <= 4'd0;
            s1_clip  <= CLIP_MAX;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_last  <= in_last;
                s1_data  <= in_data;
                s1_mode  <= mode_q;
                s1_shift <= shift_q;
                s1_clip  <= clip_q;
            end
        end
    end

    // Lane-wise activation of the stage-1 beat; lanes are fully independent.
    always_comb begin
        act_data = '0;
        for (int i = 0; i < LANE; i++) begin
            act_data[i*DWIDTH +: DWIDTH] =
                act_lane(s1_data[i*DWIDTH +: DWIDTH], s1_mode, s1_shift, s1_clip);
        end
    end

    // Stage 2: output register, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= act_data;
                out_last <= s1_last;
            end
        end
    end

    // Count of transferred output beats, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst)
            out_count <= '0;
        else if (out_valid && out_ready)
            out_count <= out_count + 1'b1;
    end

endmodule

// File: tb/tb_renkon_act.sv
// tb_renkon_act: scoreboard bench for renkon_act.
// Expected beats come from an arithmetic reference model; a monitor pops and compares.
module tb_renkon_act;

    localparam int D = 16;
    localparam int L = 8;
    localparam int C = 16;
    localparam int W = D * L;

    logic          clk;
    logic          rst;
    logic          cfg_we;
    logic [1:0]    cfg_mode;
    logic [3:0]    cfg_shift;
    logic [D-1:0]  cfg_clip;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [W-1:0]  out_data;
    logic [C-1:0]  out_count;

    renkon_act #(.DWIDTH(D), .LANE(L), .CWIDTH(C)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_mode(cfg_mode),
        .cfg_shift(cfg_shift), .cfg_clip(cfg_clip),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_data(out_data),
        .out_count(out_count)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        int           acc;
    } exp_t;

    exp_t         sbq[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           m_mode = 1;
    int           m_shift = 0;
    int           m_clip = 32767;
    logic [C-1:0] m_count = '0;
    int           rdy_mode = 0;
    bit           lat_strict = 1;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference activation from plain integer arithmetic.
    function automatic int ref_lane(input int x, input int md, input int sh,
                                    input int cl);
        int p;
        p = 1 << sh;
        case (md)
            0: return x;
            1: return (x > 0) ? x : 0;
            2: begin
                if (x >= 0) return x;
                return (x - (p - 1)) / p;
            end
            default: begin
                if (cl <= 0 || x <= 0) return 0;
                if (x > cl) return cl;
                return x;
            end
        endcase
    endfunction

    function automatic logic [W-1:0] ref_beat(input logic [W-1:0] d,
                                              input int md, input int sh,
                                              input int cl);
        logic [W-1:0] r;
        int x;
        int y;
        r = '0;
        for (int i = 0; i < L; i++) begin
            x = $signed(d[i*D +: D]);
            y = ref_lane(x, md, sh, cl);
            r[i*D +: D] = y[D-1:0];
        end
        return r;
    endfunction

    function automatic logic [D-1:0] rnd_lane();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'hFFFF;
            2: return 16'h0000;
            3: return 16'h0001;
            4: return 16'h7FFF;
            default: return D'($urandom);
        endcase
    endfunction

    function automatic logic [W-1:0] rnd_beat();
        logic [W-1:0] r;
        for (int i = 0; i < L; i++) r[i*D +: D] = rnd_lane();
        return r;
    endfunction

    function automatic logic [W-1:0] pack(input int v[L]);
        logic [W-1:0] r;
        int t;
        for (int i = 0; i < L; i++) begin
            t = v[i];
            r[i*D +: D] = t[D-1:0];
        end
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [W-1:0] d, input logic last,
                             input bit do_cfg, input logic [1:0] md,
                             input logic [3:0] sh, input logic [D-1:0] cl);
        exp_t e;
        int   n;
        bit   done;
        n = 0;
        done = 0;
        in_valid = 1;
        in_data  = d;
        in_last  = last;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e.data = ref_beat(d, m_mode, m_shift, m_clip);
                e.last = last;
                e.acc  = cyc;
                sbq.push_back(e);
                if (do_cfg) begin
                    cfg_we = 1;
                    cfg_mode = md;
                    cfg_shift = sh;
                    cfg_clip = cl;
                end
                done = 1;
            end else begin
                n++;
                if (n > 300) begin
                    chk("accept_timeout", 0, 1);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        if (do_cfg) begin
            cfg_we = 0;
            m_mode = md;
            m_shift = sh;
            m_clip = $signed(cl);
        end
    endtask

    task automatic write_cfg(input logic [1:0] md, input logic [3:0] sh,
                             input logic [D-1:0] cl);
        cfg_we = 1;
        cfg_mode = md;
        cfg_shift = sh;
        cfg_clip = cl;
        @(posedge clk);
        #1;
        cfg_we = 0;
        m_mode = md;
        m_shift = sh;
        m_clip = $signed(cl);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", W'(sbq.size()), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Downstream ready generator.
    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) out_ready = 1;
            else if (rdy_mode == 1) out_ready = ($urandom_range(0, 9) < 6);
        end
    end

    // Monitor: stall stability, transfer ordering, count and latency.
    initial begin
        bit           prev_stall;
        logic [W-1:0] prev_data;
        logic         prev_last;
        exp_t         e;
        prev_stall = 0;
        prev_data = '0;
        prev_last = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sbq.delete();
                m_count = '0;
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", W'(out_valid), 1);
                    chk("stall_data", out_data, prev_data);
                    chk("stall_last", W'(out_last), W'(prev_last));
                end
                if (out_valid && !out_ready)
                    chk("stall_in_ready", W'(in_ready), 0);
                if (out_valid && out_ready) begin
                    chk("out_count", W'(out_count), W'(m_count));
                    if (sbq.size() == 0) begin
                        chk("unexpected_beat", out_data, '0);
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("out_data", out_data, e.data);
                        chk("out_last", W'(out_last), W'(e.last));
                        if (lat_strict)
                            chk("latency", W'(cyc - e.acc), 2);
                    end
                    m_count = m_count + 1'b1;
                end
                prev_stall = out_valid && !out_ready;
                prev_data = out_data;
                prev_last = out_last;
            end
        end
    end

    initial begin
        int           v[L];
        logic [C-1:0] c0;
        rst = 1;
        cfg_we = 0;
        cfg_mode = 0;
        cfg_shift = 0;
        cfg_clip = 0;
        in_valid = 0;
        in_last = 0;
        in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_out_last", W'(out_last), 0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_count", W'(out_count), 0);
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("rst_in_ready", W'(in_ready), 1);
        @(posedge clk);
        #1;

        v = '{5, -3, 0, 32767, 0, 0, 0, 0};
        send_beat(pack(v), 0, 0, 0, 0, 0);
        drain();

        write_cfg(2, 2, 0);
        v = '{-8, -1, 7, -32768, 1, -5, 0, 32767};
        send_beat(pack(v), 0, 0, 0, 0, 0);
        drain();

        write_cfg(3, 0, 6);
        v = '{-4, 3, 6, 100, 0, 7, 5, -32768};
        send_beat(pack(v), 0, 0, 0, 0, 0);
        write_cfg(3, 0, 16'hFFFF);
        send_beat(rnd_beat(), 0, 0, 0, 0, 0);
        write_cfg(3, 0, 16'h0000);
        send_beat(rnd_beat(), 0, 0, 0, 0, 0);
        drain();

        write_cfg(1, 0, 16'h7FFF);
        v = '{-9, -1, -32768, 4, 0, -2, 3, -7};
        send_beat(pack(v), 0, 0, 0, 0, 0);
        send_beat(pack(v), 0, 0, 0, 0, 0);
        write_cfg(0, 0, 16'h7FFF);
        send_beat(pack(v), 1, 0, 0, 0, 0);
        drain();

        send_beat(pack(v), 0, 1, 1, 0, 16'h7FFF);
        send_beat(pack(v), 0, 1, 2, 1, 16'h7FFF);
        send_beat(pack(v), 0, 0, 0, 0, 0);
        drain();

        lat_strict = 0;
        rdy_mode = 2;
        c0 = out_count;
        fork
            for (int i = 0; i < 10; i++)
                send_beat(rnd_beat(), (i == 9), 0, 0, 0, 0);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1;
            end
        join
        drain();
        chk("stall_count10", W'(out_count - c0), 10);
        rdy_mode = 0;

        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0: write_cfg(2'($urandom), 4'($urandom), rnd_lane());
                1: send_beat(rnd_beat(), 1'($urandom), 1, 2'($urandom),
                             4'($urandom), rnd_lane());
                2: begin
                    @(posedge clk);
                    #1;
                end
                default: send_beat(rnd_beat(), 1'($urandom), 0, 0, 0, 0);
            endcase
        end
        rdy_mode = 0;
        drain();
        lat_strict = 1;

        write_cfg(1, 0, 16'h7FFF);
        send_beat(rnd_beat(), 0, 0, 0, 0, 0);
        send_beat(rnd_beat(), 1, 0, 0, 0, 0);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        m_mode = 1;
        m_shift = 0;
        m_clip = 32767;
        @(negedge clk);
        chk("rst_mid_valid", W'(out_valid), 0);
        chk("rst_mid_count", W'(out_count), 0);
        chk("rst_mid_in_ready", W'(in_ready), 1);
        repeat (6) @(posedge clk);
        #1;
        chk("rst_mid_count_idle", W'(out_count), 0);
        v = '{-5, 5, -32768, 32767, 0, -1, 1, 2};
        send_beat(pack(v), 1, 0, 0, 0, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
